// File: rtl/instr_encoder_writer.sv
// instr_encoder_writer: packs RV32I fields into instruction words and streams them to the IMEM write port.
// Optional macro IMM_CHECK_EN enables per-beat immediate range checking with a sticky err flag.
module instr_encoder_writer #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int DEPTH = 256,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [2:0]        funct3,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [CW-1:0]     count,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic              err
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t state, state_nx;
  logic [31:0] enc;
  logic bad, accept;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    state_nx = start ? LOAD : (state == LOAD && finish) ? DONE : state;
  end
  assign busy     = state == LOAD;
  assign done     = state == DONE;
  assign full     = count == CW'(DEPTH);
  assign in_ready = busy & ~full & ~start;
  assign accept   = in_valid & in_ready;
  always_comb begin
    enc = 32'h0000_0013;
    enc = fmt == 3'd0 ? {funct7, rs2, rs1, funct3, rd, opcode}
        : fmt == 3'd1 ? {imm[11:0], rs1, funct3, rd, opcode}
        : fmt == 3'd2 ? {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
        : fmt == 3'd3 ? {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
        : fmt == 3'd4 ? {imm[31:12], rd, opcode}
        : fmt == 3'd5 ? {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
        : 32'h0000_0013;
  end
`ifdef IMM_CHECK_EN
  // An immediate fits an N-bit signed field when bits [31:N-1] are all equal.
  logic fit12, fit13, fit21;
  assign fit12 = &imm[31:11] | ~|imm[31:11];
  assign fit13 = &imm[31:12] | ~|imm[31:12];
  assign fit21 = &imm[31:20] | ~|imm[31:20];
  always_comb begin
    bad = 1'b0;
    bad = (fmt == 3'd1 || fmt == 3'd2) ? ~fit12
        : fmt == 3'd3 ? (~fit13 | imm[0])
        : fmt == 3'd4 ? |imm[11:0]
        : fmt == 3'd5 ? (~fit21 | imm[0])
        : fmt > 3'd5;
  end
`else
  assign bad = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= '0;
      count      <= '0;
      err        <= 1'b0;
    end else begin
      imem_we <= accept & ~bad;
      if (start) begin
        count     <= '0;
        err       <= 1'b0;
        imem_addr <= BASE_ADDR;
      end else if (accept && bad) begin
        err <= 1'b1;
      end else if (accept) begin
        imem_addr  <= BASE_ADDR + (ADDR_W'(count) << 2);
        imem_wdata <= enc;
        count      <= count + CW'(1);
      end
    end
endmodule
